// File: rtl/mm_seq_pkg.sv
// Shared types and width helpers for the tile sequencer.
//   state_e     : sequencer FSM states
//   idx_w()     : index width for a count of n items (minimum 1 bit)
//   LOAD_IDX_W, SEL_W, WAIT_W : widths for the default configuration
package mm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int LOAD_IDX_W = idx_w(8);   // 8 operand registers
  localparam int SEL_W      = idx_w(4);   // 4 results per tile
  localparam int WAIT_W     = idx_w(16);  // compute wait 0..15

endpackage

// File: rtl/mm_step_counter.sv
// Wrapping step counter used for the load, wait and store phases.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : advance one step (wraps to 0 after MAX-1)
//   i_clr          : synchronous clear, wins over i_en
//   o_nxt          : value the counter will hold after this edge
//   o_tc           : current value is the last step (MAX-1)
module mm_step_counter import mm_seq_pkg::*; #(
  parameter int MAX = 4,
  parameter int W   = idx_w(MAX)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_nxt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;

  assign o_tc  = (r_cnt == W'(MAX - 1));
  assign o_nxt = w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_clr)      w_nxt = '0;
    else if (i_en)  w_nxt = o_tc ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= w_nxt;
  end

endmodule

// File: rtl/mm_tile_sequencer.sv
// Multi-tile matrix-multiply sequencer: per tile, NUM_LOAD one-hot operand
// loads, COMPUTE_WAIT idle cycles, then NUM_STORE result stores.
//   i_clk, i_rst_n  : clock, async active-low reset (aborts a run, no done)
//   i_start         : begin run, sampled only in IDLE; latches i_num_tiles
//   i_num_tiles     : tiles to run (0 -> straight to done)
//   i_stall         : memory not ready; freezes sequencer, masks strobes
//   o_busy, o_done  : busy from accepted start until done; done one-cycle pulse
//   o_we            : one-hot operand write enable
//   o_data_we       : memory store enable
//   o_store_sel     : result mux select; o_column is its MSB
//   o_next_row      : advance source-row address on last load of each row
// Optional: MM_TILE_SEQ_PERF_EN adds o_cycle_cnt / o_stall_cnt (busy cycles,
// busy&&stall cycles; cleared on accepted start, held after done).
module mm_tile_sequencer import mm_seq_pkg::*; #(
  parameter  int NUM_LOAD      = 8,
  parameter  int LOADS_PER_ROW = 2,
  parameter  int NUM_STORE     = 4,
  parameter  int COMPUTE_WAIT  = 0,
  parameter  int TILE_W        = 8,
  localparam int LD_W          = idx_w(NUM_LOAD),
  localparam int ST_W          = idx_w(NUM_STORE),
  localparam int WT_MAX        = (COMPUTE_WAIT > 0) ? COMPUTE_WAIT : 1,
  localparam int WT_W          = idx_w(WT_MAX)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [TILE_W-1:0]    i_num_tiles,
  input  logic                 i_stall,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NUM_LOAD-1:0]  o_we,
  output logic                 o_data_we,
  output logic [ST_W-1:0]      o_store_sel,
  output logic                 o_next_row,
  output logic                 o_column
`ifdef MM_TILE_SEQ_PERF_EN
  ,
  output logic [31:0]          o_cycle_cnt,
  output logic [31:0]          o_stall_cnt
`endif
);

  state_e              r_state;
  logic [TILE_W-1:0]   r_tiles;
  logic                r_busy, r_done, r_data_we, r_next_row;
  logic [NUM_LOAD-1:0] r_we;
  logic [ST_W-1:0]     r_store_sel;

  logic                w_go;
  logic [LD_W-1:0]     w_ld_nxt;
  logic                w_ld_tc;
  logic [WT_W-1:0]     w_wt_nxt_unused;  // wait phase only needs the terminal flag
  logic                w_wt_tc;
  logic [ST_W-1:0]     w_st_nxt;
  logic                w_st_tc;
  logic [NUM_LOAD-1:0] w_we_nxt;
  logic                w_nrow_nxt;

  assign w_go = (r_state == IDLE) && i_start;

  // Counters only advance in their own phase and only when not stalled.
  // Each wraps to 0 on its last step, so it is already at step 0 whenever
  // its phase is next entered.
  mm_step_counter #(.MAX(NUM_LOAD)) u_ld_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en((r_state == LOAD) && !i_stall), .i_clr(w_go),
    .o_nxt(w_ld_nxt), .o_tc(w_ld_tc)
  );

  mm_step_counter #(.MAX(WT_MAX)) u_wt_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en((r_state == WAIT) && !i_stall), .i_clr(w_go),
    .o_nxt(w_wt_nxt_unused), .o_tc(w_wt_tc)
  );

  mm_step_counter #(.MAX(NUM_STORE)) u_st_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en((r_state == STORE) && !i_stall), .i_clr(w_go),
    .o_nxt(w_st_nxt), .o_tc(w_st_tc)
  );

  // Strobes for the load step about to be presented.
  always_comb begin
    w_we_nxt           = '0;
    w_we_nxt[w_ld_nxt] = 1'b1;
  end
  assign w_nrow_nxt = ((int'(w_ld_nxt) % LOADS_PER_ROW) == (LOADS_PER_ROW - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_tiles     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= '0;
      r_data_we   <= 1'b0;
      r_store_sel <= '0;
      r_next_row  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_tiles <= i_num_tiles;
          if (i_num_tiles == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= LOAD;
            r_busy     <= 1'b1;
            r_we       <= w_we_nxt;
            r_next_row <= w_nrow_nxt;
          end
        end
        LOAD: if (!i_stall) begin
          if (w_ld_tc) begin
            r_we       <= '0;
            r_next_row <= 1'b0;
            if (COMPUTE_WAIT > 0) begin
              r_state <= WAIT;
            end else begin
              r_state     <= STORE;
              r_data_we   <= 1'b1;
              r_store_sel <= '0;
            end
          end else begin
            r_we       <= w_we_nxt;
            r_next_row <= w_nrow_nxt;
          end
        end
        WAIT: if (!i_stall && w_wt_tc) begin
          r_state     <= STORE;
          r_data_we   <= 1'b1;
          r_store_sel <= '0;
        end
        STORE: if (!i_stall) begin
          if (!w_st_tc) begin
            r_store_sel <= w_st_nxt;
          end else begin
            r_data_we   <= 1'b0;
            r_store_sel <= '0;
            r_tiles     <= r_tiles - TILE_W'(1);
            if (r_tiles == TILE_W'(1)) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // next tile starts immediately, no gap cycle
              r_state    <= LOAD;
              r_we       <= w_we_nxt;
              r_next_row <= w_nrow_nxt;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall masks the strobes combinationally; the select lines keep their value.
  assign o_we        = i_stall ? '0 : r_we;
  assign o_data_we   = r_data_we  & ~i_stall;
  assign o_next_row  = r_next_row & ~i_stall;
  assign o_store_sel = r_store_sel;
  assign o_column    = r_store_sel[ST_W-1];
  assign o_busy      = r_busy;
  assign o_done      = r_done;

`ifdef MM_TILE_SEQ_PERF_EN
  logic [31:0] r_cycle_cnt, r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (w_go) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (r_busy) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (i_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// Scoreboard bench for mm_tile_sequencer: instance A uses defaults,
// instance B uses COMPUTE_WAIT=2. Expected strobe events (with cycle offset
// from the accepted start edge) are queued by the stimulus; negedge monitors
// pop and compare whenever an instance shows we/data_we/done.
module tb_mm_tile_sequencer;

  typedef struct packed {
    logic [31:0] t;
    logic [7:0]  we;
    logic        dwe;
    logic [1:0]  sel;
    logic        col;
    logic        nr;
    logic        busy;
    logic        done;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_start, a_stall, b_start, b_stall;
  logic [7:0] a_num, b_num;
  logic       a_busy, a_done, a_dwe, a_nr, a_col;
  logic       b_busy, b_done, b_dwe, b_nr, b_col;
  logic [7:0] a_we, b_we;
  logic [1:0] a_sel, b_sel;
`ifdef MM_TILE_SEQ_PERF_EN
  logic [31:0] a_cyc_cnt, a_stl_cnt, b_cyc_cnt, b_stl_cnt;
`endif

  int n_tests = 0, n_fail = 0;
  int cyc = 0, sa = 0, sb = 0;
  ev_t qa[$], qb[$];

  mm_tile_sequencer u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_num_tiles(a_num),
    .i_stall(a_stall), .o_busy(a_busy), .o_done(a_done), .o_we(a_we),
    .o_data_we(a_dwe), .o_store_sel(a_sel), .o_next_row(a_nr), .o_column(a_col)
`ifdef MM_TILE_SEQ_PERF_EN
    , .o_cycle_cnt(a_cyc_cnt), .o_stall_cnt(a_stl_cnt)
`endif
  );

  mm_tile_sequencer #(.COMPUTE_WAIT(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_num_tiles(b_num),
    .i_stall(b_stall), .o_busy(b_busy), .o_done(b_done), .o_we(b_we),
    .o_data_we(b_dwe), .o_store_sel(b_sel), .o_next_row(b_nr), .o_column(b_col)
`ifdef MM_TILE_SEQ_PERF_EN
    , .o_cycle_cnt(b_cyc_cnt), .o_stall_cnt(b_stl_cnt)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic push(input bit to_b, input int t, input logic [7:0] we, input logic dwe,
                      input logic [1:0] sel, input logic nr, input logic busy, input logic done);
    ev_t e;
    e.t = t; e.we = we; e.dwe = dwe; e.sel = sel; e.col = sel[1];
    e.nr = nr; e.busy = busy; e.done = done;
    if (to_b) qb.push_back(e);
    else      qa.push_back(e);
  endtask

  // One tile: loads at t0..t0+7 (shifted by st_n from step st_k on), then
  // n_st stores after cw idle cycles.
  task automatic push_tile(input bit to_b, input int t0, input int cw,
                           input int st_k, input int st_n, input int n_st);
    for (int k = 0; k < 8; k++)
      push(to_b, t0 + k + ((k >= st_k) ? st_n : 0), 8'h01 << k, 1'b0, 2'd0, k[0], 1'b1, 1'b0);
    for (int s = 0; s < n_st; s++)
      push(to_b, t0 + 8 + cw + s + ((st_k < 8) ? st_n : 0), 8'h00, 1'b1, s[1:0], 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_ev(input bit b, input ev_t g0);
    ev_t e, g;
    g = g0;
    n_tests++;
    if ((b ? qb.size() : qa.size()) == 0) begin
      n_fail++;
      $display("FAIL %s unexpected_event t=%0d we=%h dwe=%b done=%b",
               b ? "B" : "A", g.t, g.we, g.dwe, g.done);
      return;
    end
    e = b ? qb.pop_front() : qa.pop_front();
    if (!e.dwe) begin g.sel = e.sel; g.col = e.col; end  // select undefined outside stores
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s event got t=%0d we=%h dwe=%b sel=%0d col=%b nr=%b busy=%b done=%b exp t=%0d we=%h dwe=%b sel=%0d col=%b nr=%b busy=%b done=%b",
               b ? "B" : "A", g.t, g.we, g.dwe, g.sel, g.col, g.nr, g.busy, g.done,
               e.t, e.we, e.dwe, e.sel, e.col, e.nr, e.busy, e.done);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (a_we != 8'h00 || a_dwe || a_done))
      chk_ev(1'b0, '{t: cyc - sa, we: a_we, dwe: a_dwe, sel: a_sel, col: a_col,
                     nr: a_nr, busy: a_busy, done: a_done});
    if (rst_n && (b_we != 8'h00 || b_dwe || b_done))
      chk_ev(1'b1, '{t: cyc - sb, we: b_we, dwe: b_dwe, sel: b_sel, col: b_col,
                     nr: b_nr, busy: b_busy, done: b_done});
  end

  task automatic start_a(input logic [7:0] n);
    a_num = n; a_start = 1'b1;
    @(posedge clk); #1;
    sa = cyc; a_start = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] n);
    b_num = n; b_start = 1'b1;
    @(posedge clk); #1;
    sb = cyc; b_start = 1'b0;
  endtask

  // Wait (bounded) until the expected-event queue has been consumed.
  task automatic drain(input bit b, input int budget);
    int i = 0;
    do begin
      @(posedge clk); i++;
    end while (((b ? qb.size() : qa.size()) != 0) && i < budget);
    #1;
    chk(b ? "B_drain" : "A_drain", b ? qb.size() : qa.size(), 0);
    if (b) qb.delete();
    else   qa.delete();
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_stall = 1'b0; a_num = 8'd0;
    b_start = 1'b0; b_stall = 1'b0; b_num = 8'd0;
    repeat (2) @(posedge clk); #1;
    chk("rst_we",    {24'd0, a_we}, 0);
    chk("rst_dwe",   {31'd0, a_dwe}, 0);
    chk("rst_sel",   {30'd0, a_sel}, 0);
    chk("rst_col_nr",{30'd0, a_col, a_nr}, 0);
    chk("rst_busy",  {31'd0, a_busy}, 0);
    chk("rst_done",  {31'd0, a_done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single tile; start re-asserted during the done cycle must be ignored
    push_tile(1'b0, 0, 0, 99, 0, 4);
    push(1'b0, 12, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    start_a(8'd1);
    repeat (12) @(posedge clk); #1;
    a_num = 8'd3; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("done_start_ignored_busy", {31'd0, a_busy}, 0);
    chk("one_tile_queue", qa.size(), 0);

    // two tiles back to back; start while busy ignored
    push_tile(1'b0, 0, 0, 99, 0, 4);
    push_tile(1'b0, 12, 0, 99, 0, 4);
    push(1'b0, 24, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    start_a(8'd2);
    repeat (3) @(posedge clk); #1;
    a_num = 8'd5; a_start = 1'b1;
    repeat (3) @(posedge clk); #1;
    a_start = 1'b0;
    drain(1'b0, 40);

    // stall 3 cycles at load step 4, then 2 cycles at store step 2
    push_tile(1'b0, 0, 0, 4, 3, 2);
    push(1'b0, 15, 8'h00, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    push(1'b0, 16, 8'h00, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    push(1'b0, 17, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    start_a(8'd1);
    repeat (4) @(posedge clk); #1;
    a_stall = 1'b1;
    repeat (3) @(posedge clk); #1;
    a_stall = 1'b0;
    repeat (6) @(posedge clk); #1;
    a_stall = 1'b1;
    @(negedge clk);
    chk("stall_sel_hold", {30'd0, a_sel}, 2);
    chk("stall_col_hold", {31'd0, a_col}, 1);
    chk("stall_dwe_mask", {31'd0, a_dwe}, 0);
    @(posedge clk);
    @(posedge clk); #1;
    a_stall = 1'b0;
    drain(1'b0, 40);
`ifdef MM_TILE_SEQ_PERF_EN
    chk("perf_cycle_cnt", a_cyc_cnt, 17);
    chk("perf_stall_cnt", a_stl_cnt, 5);
`endif

    // zero tiles: done right after start, no strobes
    push(1'b0, 0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    start_a(8'd0);
    drain(1'b0, 10);

    // reset during STORE aborts with no done; next run starts clean
    push_tile(1'b0, 0, 0, 99, 0, 2);
    start_a(8'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_dwe",   {23'd0, a_we, a_dwe}, 0);
    chk("abort_sel_col",  {29'd0, a_sel, a_col}, 0);
    chk("abort_nr_busy_done", {29'd0, a_nr, a_busy, a_done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("abort_queue", qa.size(), 0);
    push_tile(1'b0, 0, 0, 99, 0, 4);
    push(1'b0, 12, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    start_a(8'd1);
    drain(1'b0, 40);

    // compute wait of 2 idle cycles before the stores
    push_tile(1'b1, 0, 2, 99, 0, 4);
    push(1'b1, 14, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    start_b(8'd1);
    drain(1'b1, 40);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
